program_loader: RTL
===================

# program_loader

Boot-time instruction loader sitting directly upstream of the single-cycle RISC-V core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them sequentially into instruction memory. While loading, it holds the core in reset through an active-low `cpu_rstn` output, and releases the core only after a complete, valid image has been written.

## Interface
- `NUM_INST`, 128: instruction memory depth in words; maximum accepted image length.
- `ADDR_W`, `$clog2(NUM_INST)`: width of the instruction-memory word address.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_data` holds a byte.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle; a transfer occurs on `in_valid && in_ready`.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  instruction word.
- `cpu_rstn`  out  1  active-low reset to the core; 0 until the image is loaded.
- `done`  out  1  image loaded successfully; sticky until `rst`.
- `error`  out  1  image rejected; sticky until `rst`.

## Operation
- Stream format:
  - LEN0: count low byte.
  - LEN1: count high byte, giving a 16-bit word count N.
  - Then N×4 data bytes, least-significant byte first per word.
  - With checksum enabled, one trailing checksum byte follows.
- States: LEN0, LEN1, DATA, CHK, DONE, ERR.
- Transitions:
  - LEN0 → LEN1 on handshake.
  - LEN1:
    - N > NUM_INST → ERR.
    - N == 0 → DONE, or CHK if checksum is enabled.
    - Otherwise → DATA.
  - DATA: a 2-bit byte counter shifts each byte into its lane. On the 4th byte, the word is written at the current word index and the index increments. After word N-1 → DONE, or CHK if checksum is enabled.
  - CHK → DONE on match, ERR on mismatch.
  - DONE and ERR are terminal until `rst`.
- `in_ready` = 1 in LEN0, LEN1, DATA and CHK; 0 in DONE and ERR. The loader never stalls inside a word.
- Word index wraps are impossible: N ≤ NUM_INST is enforced before DATA is entered.
- Bytes offered while `in_valid` = 0 are ignored. The state holds indefinitely between bytes.
- `rst` mid-load:
  - All state returns to LEN0 and `cpu_rstn` drops to 0 asynchronously.
  - Partially written memory is not cleared; a fresh image overwrites it.

## Timing
- Reset values: `in_ready` 0 while `rst` is asserted, then 1 (LEN0). `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `cpu_rstn` 0, `done` 0, `error` 0.
- All outputs are registered. The handshake of the 4th byte of a word at edge k drives `imem_we` = 1 with valid `imem_addr`/`imem_wdata` for exactly the cycle following edge k.
- The final accepted byte (last data byte, or checksum byte) at edge k gives `done` = 1 from edge k.
- `cpu_rstn` = 1 from edge k+1. The last memory write therefore completes before the core's first fetch.
- The reject condition evaluated at handshake edge k gives `error` = 1 and `in_ready` = 0 from edge k. `cpu_rstn` stays 0.
- Throughput: one byte per cycle; back-to-back words produce consecutive `imem_we` pulses.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - An 8-bit XOR accumulator covers every data byte, excluding the length bytes.
  - The CHK state requires one extra byte equal to the accumulator; a mismatch goes to ERR.
  - For N == 0, the expected checksum is 0x00.
- Not defined: no CHK state, no accumulator. DONE is entered on the last data byte, or on LEN1 when N == 0.

## Test plan
- Stream 02 00 13 00 00 00 B3 00 50 00, sent one byte per cycle without the checksum macro:
  - write addr 0 = 0x00000013;
  - write addr 1 = 0x005000B3;
  - `done` on the last byte edge, `cpu_rstn` one cycle later;
  - `in_ready` 0 afterwards.
- Length 0x0081 (129 > 128): `error` = 1 after LEN1, no `imem_we`, `cpu_rstn` stays 0, `in_ready` 0.
- Length 0 (00 00): `done` = 1 after LEN1, or after checksum byte 00 when enabled; no writes.
- With `LOADER_CHECKSUM_EN`, one word 13 00 00 00:
  - checksum 0x13 → `done`;
  - separate run with checksum 0x12 → `error`; the write to addr 0 still occurred.
- `in_valid` toggled randomly across a 3-word image: writes, addresses and words are identical to the back-to-back run.
- Assert `rst` after 6 bytes of a 2-word image: outputs return to reset values immediately; a full 1-word image afterwards loads to addr 0 and completes.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: boot-time byte-stream loader for the core's instruction memory.
// Stream: LEN0, LEN1 (16-bit word count N), then N little-endian 32-bit words.
// Optional feature macro LOADER_CHECKSUM_EN: adds a trailing XOR checksum byte
// over all data bytes, checked in a dedicated CHK state.
module program_loader #(
  parameter int unsigned NUM_INST = 128,
  parameter int unsigned ADDR_W   = $clog2(NUM_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              error
);

  localparam logic [15:0] MAX_WORDS = 16'(NUM_INST);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR} state_t;
`endif

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [23:0]         lanes_q, lanes_d;
  logic                in_ready_d, we_d, done_d, error_d, cpu_rstn_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [31:0]         wdata_d;
  logic                xfer;
  logic [15:0]         n_words;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          acc_q, acc_d;
`endif

  // Next-state and next-output logic; every register value is computed here.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    lanes_d    = lanes_q;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
    done_d     = done;
    error_d    = error;
    cpu_rstn_d = done;
`ifdef LOADER_CHECKSUM_EN
    acc_d      = acc_q;
`endif
    xfer       = in_valid && in_ready;
    n_words    = {in_data, len_q[7:0]};

    case (state_q)
      S_LEN0: begin
        if (xfer) begin
          len_d   = {8'h00, in_data};
          state_d = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d = n_words;
          idx_d = '0;
          cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          acc_d = 8'h00;
`endif
          if (n_words > MAX_WORDS) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (n_words == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          cnt_d = cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          acc_d = acc_q ^ in_data;
`endif
          case (cnt_q)
            2'd0:    lanes_d[7:0]   = in_data;
            2'd1:    lanes_d[15:8]  = in_data;
            2'd2:    lanes_d[23:16] = in_data;
            default: begin
              // Fourth byte completes the word: write it and advance.
              we_d    = 1'b1;
              addr_d  = idx_q;
              wdata_d = {in_data, lanes_q};
              idx_d   = idx_q + ADDR_W'(1);
              if (16'(idx_q) == (len_q - 16'd1)) begin
`ifdef LOADER_CHECKSUM_EN
                state_d = S_CHK;
`else
                state_d = S_DONE;
                done_d  = 1'b1;
`endif
              end
            end
          endcase
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          if (in_data == acc_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: ;
    endcase

    in_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
  end

  // State and output registers; reset returns to LEN0 with the core held in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LEN0;
      len_q      <= 16'd0;
      idx_q      <= '0;
      cnt_q      <= 2'd0;
      lanes_q    <= 24'd0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_rstn   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      lanes_q    <= lanes_d;
      in_ready   <= in_ready_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      cpu_rstn   <= cpu_rstn_d;
      done       <= done_d;
      error      <= error_d;
`ifdef LOADER_CHECKSUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

endmodule
